// File: rtl/blink_pkg.sv
// ============================================================================
// Module : blink_pkg
// Brief  : Shared IO map, status bit indices and width helper for the Blink RTC
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package blink_pkg;

    localparam logic [7:0] TACK = 8'hB4;
    localparam logic [7:0] TMK  = 8'hB5;
    localparam logic [7:0] TIM0 = 8'hD0;
    localparam logic [7:0] TIM1 = 8'hD1;
    localparam logic [7:0] TIM2 = 8'hD2;
    localparam logic [7:0] TIM3 = 8'hD3;
    localparam logic [7:0] TIM4 = 8'hD4;

    localparam int TS_TICK = 0;
    localparam int TS_SEC  = 1;
    localparam int TS_MIN  = 2;
    localparam int TS_ALM  = 3;

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/blink_modn_counter.sv
// ============================================================================
// Module : blink_modn_counter
// Brief  : Enabled modulo-MOD counter with synchronous clear and wrap carry
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module blink_modn_counter #(
    parameter int W   = 8,
    parameter int MOD = 256
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clr,
    input  logic         i_en,
    output logic [W-1:0] o_count,
    output logic         o_carry
);

    localparam logic [W-1:0] c_LAST = W'(MOD - 1);

    logic [W-1:0] r_count;
    logic         w_at_last;

    assign w_at_last = (r_count == c_LAST);
    assign o_carry   = i_en & w_at_last;
    assign o_count   = r_count;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= w_at_last ? '0 : r_count + W'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/blink_rtc_timer.sv
// ============================================================================
// Module : blink_rtc_timer
// Brief  : Tick/second/minute RTC with minute alarm, sticky status and IRQ
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module blink_rtc_timer #(
    parameter int         CLK_DIV  = 49152,
    parameter int         TICKS    = 200,
    parameter int         SECS     = 60,
    parameter int         MIN_W    = 21,
    parameter logic [7:0] ALM_BASE = 8'hD8
) (
    input  logic       mck,
    input  logic       rin,
    input  logic       restim,
    input  logic       gie,
    input  logic       io_wr,
    input  logic       io_rd,
    input  logic [7:0] io_addr,
    input  logic [7:0] io_wdata,
    output logic [7:0] io_rdata,
    output logic       io_hit,
    output logic [3:0] tsta,
    output logic       irq
);

    import blink_pkg::*;

    localparam int c_PW  = cnt_width(CLK_DIV);
    localparam int c_T0W = cnt_width(TICKS);
    localparam int c_T1W = cnt_width(SECS);
    localparam logic [c_PW-1:0] c_PLAST = c_PW'(CLK_DIV - 1);

    logic [c_PW-1:0]  w_pcnt;
    logic [c_T0W-1:0] w_tim0;
    logic [c_T1W-1:0] w_tim1;
    logic             w_pcarry, w_tick, w_sec_ev, w_min_ev, w_alm_ev;
    logic [MIN_W-1:0] w_timm_inc;
    logic [3:0]       w_tsta_set, w_ack, w_tsta_next;
    logic [7:0]       w_rd_mux;
    logic             w_rd_hit;

    logic [MIN_W-1:0] r_timm, r_alm, r_snap_timm;
    logic [c_T1W-1:0] r_snap_tim1;
    logic             r_alm_en, r_irq, r_hit;
    logic [3:0]       r_tsta, r_tmk;
    logic [7:0]       r_rdata;

    blink_modn_counter #(.W(c_PW), .MOD(CLK_DIV)) u_presc (
        .clk(mck), .rst(rin), .i_clr(restim), .i_en(1'b1),
        .o_count(w_pcnt), .o_carry(w_pcarry)
    );

    assign w_tick = w_pcarry & ~restim;

    blink_modn_counter #(.W(c_T0W), .MOD(TICKS)) u_tim0 (
        .clk(mck), .rst(rin), .i_clr(restim), .i_en(w_tick),
        .o_count(w_tim0), .o_carry(w_sec_ev)
    );

    blink_modn_counter #(.W(c_T1W), .MOD(SECS)) u_tim1 (
        .clk(mck), .rst(rin), .i_clr(restim), .i_en(w_sec_ev),
        .o_count(w_tim1), .o_carry(w_min_ev)
    );

    assign w_timm_inc = r_timm + MIN_W'(1);
    assign w_alm_ev   = w_min_ev & r_alm_en & (w_timm_inc == r_alm);

    // A set event in the same cycle as an acknowledge keeps the bit.
    always_comb begin
        w_tsta_set          = 4'b0000;
        w_tsta_set[TS_TICK] = w_tick;
        w_tsta_set[TS_SEC]  = w_sec_ev;
        w_tsta_set[TS_MIN]  = w_min_ev;
        w_tsta_set[TS_ALM]  = w_alm_ev;
        w_ack               = (io_wr && io_addr == TACK) ? io_wdata[3:0] : 4'b0000;
        w_tsta_next         = restim ? 4'b0000 : ((r_tsta & ~w_ack) | w_tsta_set);
    end

    always_comb begin
        w_rd_mux = 8'h00;
        w_rd_hit = 1'b1;
        case (io_addr)
            TMK:              w_rd_mux = {4'b0000, r_tsta};
            TIM0:             w_rd_mux = 8'(w_tim0);
            TIM1:             w_rd_mux = 8'(r_snap_tim1);
            TIM2:             w_rd_mux = r_snap_timm[7:0];
            TIM3:             w_rd_mux = r_snap_timm[15:8];
            TIM4:             w_rd_mux = 8'(r_snap_timm[MIN_W-1:16]);
            ALM_BASE:         w_rd_mux = r_alm[7:0];
            ALM_BASE + 8'd1:  w_rd_mux = r_alm[15:8];
            ALM_BASE + 8'd2:  w_rd_mux = {r_alm_en, 7'(r_alm[MIN_W-1:16])};
            default:          w_rd_hit = 1'b0;
        endcase
    end

    always_ff @(posedge mck) begin
        if (rin) begin
            r_timm      <= '0;
            r_tsta      <= '0;
            r_tmk       <= '0;
            r_alm       <= '0;
            r_alm_en    <= 1'b0;
            r_snap_timm <= '0;
            r_snap_tim1 <= '0;
            r_rdata     <= '0;
            r_hit       <= 1'b0;
            r_irq       <= 1'b0;
        end else begin
            if (restim) begin
                r_timm <= '0;
            end else if (w_min_ev) begin
                r_timm <= w_timm_inc;
            end
            r_tsta <= w_tsta_next;
            r_irq  <= gie & |(w_tsta_next & r_tmk);

            if (io_wr) begin
                if (io_addr == TMK)               r_tmk       <= io_wdata[3:0];
                if (io_addr == ALM_BASE)          r_alm[7:0]  <= io_wdata;
                if (io_addr == ALM_BASE + 8'd1)   r_alm[15:8] <= io_wdata;
                if (io_addr == ALM_BASE + 8'd2) begin
                    r_alm[MIN_W-1:16] <= io_wdata[MIN_W-17:0];
                    r_alm_en          <= io_wdata[7];
                end
            end

            // Reads see pre-write values; a TIM0 read freezes the upper fields.
            if (io_rd) begin
                r_rdata <= w_rd_mux;
                r_hit   <= w_rd_hit;
                if (io_addr == TIM0) begin
                    r_snap_timm <= r_timm;
                    r_snap_tim1 <= w_tim1;
                end
            end else begin
                r_rdata <= 8'h00;
                r_hit   <= 1'b0;
            end
        end
    end

    // Bit 7 of ALM_BASE+2 carries alm_en, so the upper alarm field must fit below it.
    always_ff @(posedge mck) begin
        if (!rin) begin
            assert (MIN_W >= 17 && MIN_W <= 23)
                else $error("blink_rtc_timer: MIN_W must be in 17..23");
            assert (w_pcarry == (w_pcnt == c_PLAST))
                else $error("blink_rtc_timer: prescaler carry inconsistent");
        end
    end

    assign io_rdata = r_rdata;
    assign io_hit   = r_hit;
    assign tsta     = r_tsta;
    assign irq      = r_irq;

endmodule

`default_nettype wire

// File: tb/tb_blink_rtc_timer.sv
// ============================================================================
// Module : tb_blink_rtc_timer
// Brief  : Self-checking bench with an elapsed-time reference model
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_blink_rtc_timer;

    import blink_pkg::*;

    localparam int CLK_DIV = 4;
    localparam int TICKS   = 5;
    localparam int SECS    = 3;
    localparam int MIN_W   = 21;
    localparam int C_PT    = CLK_DIV;
    localparam int C_PS    = CLK_DIV * TICKS;
    localparam int C_PM    = CLK_DIV * TICKS * SECS;

    logic       mck = 1'b0;
    logic       rin, restim, gie, io_wr, io_rd;
    logic [7:0] io_addr, io_wdata, io_rdata;
    logic       io_hit, irq;
    logic [3:0] tsta;
    logic       b_rd;
    logic [7:0] b_addr, b_rdata;
    logic       b_hit, b_irq;
    logic [3:0] b_tsta;

    always #5 mck = ~mck;

    blink_rtc_timer #(.CLK_DIV(CLK_DIV), .TICKS(TICKS), .SECS(SECS), .MIN_W(MIN_W),
                      .ALM_BASE(8'hD8)) dut (
        .mck(mck), .rin(rin), .restim(restim), .gie(gie), .io_wr(io_wr), .io_rd(io_rd),
        .io_addr(io_addr), .io_wdata(io_wdata), .io_rdata(io_rdata), .io_hit(io_hit),
        .tsta(tsta), .irq(irq)
    );

    // Minute every cycle, so timm can reach 0xFFFF in a short run.
    blink_rtc_timer #(.CLK_DIV(1), .TICKS(1), .SECS(1), .MIN_W(MIN_W),
                      .ALM_BASE(8'hD8)) u_fast (
        .mck(mck), .rin(rin), .restim(1'b0), .gie(1'b0), .io_wr(1'b0), .io_rd(b_rd),
        .io_addr(b_addr), .io_wdata(8'h00), .io_rdata(b_rdata), .io_hit(b_hit),
        .tsta(b_tsta), .irq(b_irq)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: counters are derived from cycles elapsed since counting began.
    int          m_n;
    logic [3:0]  m_tsta, m_tmk;
    logic        m_irq, m_hit, m_alm_en;
    logic [7:0]  m_rdata;
    logic [20:0] m_alm;
    int          m_snap_timm, m_snap_t1;

    function automatic int m_t0();
        return (m_n / C_PT) % TICKS;
    endfunction
    function automatic int m_t1();
        return (m_n / C_PS) % SECS;
    endfunction
    function automatic int m_timm();
        return (m_n / C_PM) % (1 << MIN_W);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_read(input logic [7:0] a, output logic [7:0] d, output logic h);
        h = 1'b1;
        d = 8'h00;
        case (a)
            TMK:     d = {4'b0000, m_tsta};
            TIM0:    d = 8'(m_t0());
            TIM1:    d = 8'(m_snap_t1);
            TIM2:    d = 8'(m_snap_timm);
            TIM3:    d = 8'(m_snap_timm >> 8);
            TIM4:    d = 8'(m_snap_timm >> 16);
            8'hD8:   d = m_alm[7:0];
            8'hD9:   d = m_alm[15:8];
            8'hDA:   d = {m_alm_en, 2'b00, m_alm[20:16]};
            default: h = 1'b0;
        endcase
    endtask

    task automatic step();
        int          nn, nsm, nst;
        logic [3:0]  set_v, ack, nts, ntmk;
        logic        nirq, nhit, nen;
        logic [7:0]  nrd;
        logic [20:0] nalm;
        nn = m_n; nts = m_tsta; ntmk = m_tmk; nalm = m_alm; nen = m_alm_en;
        nsm = m_snap_timm; nst = m_snap_t1; nrd = 8'h00; nhit = 1'b0; nirq = 1'b0;
        if (rin) begin
            nn = 0; nts = 4'b0; ntmk = 4'b0; nalm = '0; nen = 1'b0; nsm = 0; nst = 0;
        end else begin
            if (io_rd) begin
                m_read(io_addr, nrd, nhit);
                if (io_addr == TIM0) begin
                    nsm = m_timm();
                    nst = m_t1();
                end
            end
            if (restim) begin
                nn  = 0;
                nts = 4'b0;
            end else begin
                set_v          = 4'b0;
                set_v[TS_TICK] = ((m_n % C_PT) == C_PT - 1);
                set_v[TS_SEC]  = ((m_n % C_PS) == C_PS - 1);
                set_v[TS_MIN]  = ((m_n % C_PM) == C_PM - 1);
                set_v[TS_ALM]  = set_v[TS_MIN] && m_alm_en &&
                                 (((m_n / C_PM + 1) % (1 << MIN_W)) == 32'(m_alm));
                ack = (io_wr && io_addr == TACK) ? io_wdata[3:0] : 4'b0;
                nts = (m_tsta & ~ack) | set_v;
                nn  = m_n + 1;
            end
            nirq = gie && ((nts & m_tmk) != 4'b0);
            if (io_wr) begin
                case (io_addr)
                    TMK:   ntmk = io_wdata[3:0];
                    8'hD8: nalm[7:0] = io_wdata;
                    8'hD9: nalm[15:8] = io_wdata;
                    8'hDA: begin nalm[20:16] = io_wdata[4:0]; nen = io_wdata[7]; end
                    default: ;
                endcase
            end
        end
        @(posedge mck);
        #1;
        m_n = nn; m_tsta = nts; m_tmk = ntmk; m_alm = nalm; m_alm_en = nen;
        m_snap_timm = nsm; m_snap_t1 = nst; m_rdata = nrd; m_hit = nhit; m_irq = nirq;
        check("model_tsta", 32'(tsta), 32'(m_tsta));
        check("model_irq", 32'(irq), 32'(m_irq));
        check("model_rdata", 32'(io_rdata), 32'(m_rdata));
        check("model_hit", 32'(io_hit), 32'(m_hit));
    endtask

    task automatic idle(input int k);
        repeat (k) step();
    endtask

    task automatic do_reset();
        rin = 1'b1; restim = 1'b0; gie = 1'b0; io_wr = 1'b0; io_rd = 1'b0;
        io_addr = 8'h00; io_wdata = 8'h00;
        step();
        step();
        rin = 1'b0;
    endtask

    task automatic wr_op(input logic [7:0] a, input logic [7:0] d);
        io_wr = 1'b1; io_addr = a; io_wdata = d;
        step();
        io_wr = 1'b0;
    endtask

    task automatic rd_op(input logic [7:0] a);
        io_rd = 1'b1; io_addr = a;
        step();
        io_rd = 1'b0;
    endtask

    task automatic b_read(input logic [7:0] a, input string name, input logic [7:0] exp);
        b_rd = 1'b1; b_addr = a;
        step();
        b_rd = 1'b0;
        check(name, 32'(b_rdata), 32'(exp));
        check({name, "_hit"}, 32'(b_hit), 32'd1);
    endtask

    typedef struct {
        logic       wr;
        logic       rd;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rdata;
        logic       exp_hit;
    } vec_t;

    vec_t        vt[15];
    logic [7:0]  addrs[12];
    logic        any_irq;

    initial begin
        vt[0]  = '{1'b1, 1'b0, 8'hD8, 8'h34, 8'h00, 1'b0};
        vt[1]  = '{1'b1, 1'b0, 8'hD9, 8'h12, 8'h00, 1'b0};
        vt[2]  = '{1'b1, 1'b0, 8'hDA, 8'hE5, 8'h00, 1'b0};
        vt[3]  = '{1'b0, 1'b1, 8'hD8, 8'h00, 8'h34, 1'b1};
        vt[4]  = '{1'b0, 1'b1, 8'hD9, 8'h00, 8'h12, 1'b1};
        vt[5]  = '{1'b0, 1'b1, 8'hDA, 8'h00, 8'h85, 1'b1};
        vt[6]  = '{1'b1, 1'b0, 8'hB5, 8'hFA, 8'h00, 1'b0};
        vt[7]  = '{1'b0, 1'b1, 8'hB5, 8'h00, 8'h00, 1'b1};
        vt[8]  = '{1'b0, 1'b1, 8'h42, 8'h00, 8'h00, 1'b0};
        vt[9]  = '{1'b0, 1'b1, 8'hB4, 8'h00, 8'h00, 1'b0};
        vt[10] = '{1'b0, 1'b1, 8'hD0, 8'h00, 8'h00, 1'b1};
        vt[11] = '{1'b0, 1'b1, 8'hD4, 8'h00, 8'h00, 1'b1};
        vt[12] = '{1'b1, 1'b1, 8'hDA, 8'h1F, 8'h85, 1'b1};
        vt[13] = '{1'b0, 1'b1, 8'hDA, 8'h00, 8'h1F, 1'b1};
        vt[14] = '{1'b0, 1'b1, 8'hDB, 8'h00, 8'h00, 1'b0};
        addrs = '{8'hB4, 8'hB5, 8'hD0, 8'hD1, 8'hD2, 8'hD3, 8'hD4,
                  8'hD8, 8'hD9, 8'hDA, 8'hDB, 8'h00};
        b_rd = 1'b0; b_addr = 8'h00;

        // Reset state and pre-carry snapshot on the fast instance.
        do_reset();
        check("reset_tsta", 32'(b_tsta), 32'd0);
        check("reset_irq", 32'(b_irq), 32'd0);
        idle(65535);
        b_read(TIM0, "t4_d0", 8'h00);
        b_read(TIM2, "t4_d2", 8'hFF);
        b_read(TIM3, "t4_d3", 8'hFF);
        b_read(TIM4, "t4_d4", 8'h00);
        b_read(TIM1, "t4_d1", 8'h00);
        b_read(TIM0, "t4_d0_again", 8'h00);
        b_read(TIM4, "t4_d4_after", 8'h01);

        // Register file under restim, table driven.
        do_reset();
        restim = 1'b1;
        for (int i = 0; i < 15; i++) begin
            io_wr = vt[i].wr; io_rd = vt[i].rd; io_addr = vt[i].addr; io_wdata = vt[i].wdata;
            step();
            check($sformatf("tbl%0d_rdata", i), 32'(io_rdata), 32'(vt[i].exp_rdata));
            check($sformatf("tbl%0d_hit", i), 32'(io_hit), 32'(vt[i].exp_hit));
        end
        io_wr = 1'b0; io_rd = 1'b0; restim = 1'b0;

        // T1: counting chain.
        do_reset();
        idle(19);
        check("t1_tick_only", 32'(tsta), 32'h1);
        idle(1);
        check("t1_first_sec", 32'(tsta), 32'h3);
        idle(39);
        check("t1_before_min", 32'(tsta), 32'h3);
        idle(1);
        check("t1_first_min", 32'(tsta), 32'h7);
        rd_op(TIM0);
        check("t1_tim0", 32'(io_rdata), 32'h0);
        rd_op(TIM2);
        check("t1_timm", 32'(io_rdata), 32'h1);

        // T2: acknowledge racing a tick.
        while ((m_n % C_PT) != C_PT - 1) step();
        wr_op(TACK, 8'h01);
        check("t2_ack_race", 32'(tsta[TS_TICK]), 32'd1);
        wr_op(TACK, 8'h01);
        check("t2_ack_after", 32'(tsta[TS_TICK]), 32'd0);

        // T3: interrupt mask and global enable.
        do_reset();
        gie = 1'b1;
        wr_op(TMK, 8'h02);
        idle(18);
        check("t3_no_irq_on_tick", 32'(irq), 32'd0);
        idle(1);
        check("t3_irq_on_sec", 32'(irq), 32'd1);
        wr_op(TACK, 8'h02);
        check("t3_irq_ack", 32'(irq), 32'd0);
        gie = 1'b0;
        any_irq = 1'b0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (irq) any_irq = 1'b1;
        end
        check("t3_gie_off", 32'(any_irq), 32'd0);

        // T5: minute alarm at timm == 2.
        do_reset();
        gie = 1'b1;
        wr_op(8'hD8, 8'h02);
        wr_op(8'hD9, 8'h00);
        wr_op(8'hDA, 8'h80);
        wr_op(TMK, 8'h08);
        idle(56);
        check("t5_no_alarm_min1", 32'(tsta[TS_ALM]), 32'd0);
        check("t5_no_irq_min1", 32'(irq), 32'd0);
        idle(59);
        check("t5_no_alarm_early", 32'(tsta[TS_ALM]), 32'd0);
        idle(1);
        check("t5_alarm", 32'(tsta[TS_ALM]), 32'd1);
        check("t5_alarm_irq", 32'(irq), 32'd1);
        do_reset();
        gie = 1'b1;
        wr_op(8'hD8, 8'h02);
        wr_op(TMK, 8'h08);
        idle(125);
        check("t5_alm_disabled", 32'(tsta[TS_ALM]), 32'd0);
        check("t5_alm_disabled_irq", 32'(irq), 32'd0);

        // T6: restim mid-second.
        do_reset();
        gie = 1'b1;
        wr_op(TMK, 8'h01);
        wr_op(8'hD8, 8'h5A);
        idle(28);
        restim = 1'b1;
        step();
        check("t6_tsta_held", 32'(tsta), 32'd0);
        for (int i = 0; i < 6; i++) begin
            rd_op((i % 2 == 0) ? TIM0 : TMK);
            check($sformatf("t6_read%0d", i), 32'(io_rdata), 32'd0);
        end
        restim = 1'b0;
        idle(3);
        check("t6_no_early_tick", 32'(tsta), 32'd0);
        idle(1);
        check("t6_first_tick", 32'(tsta), 32'd1);
        check("t6_tmk_kept", 32'(irq), 32'd1);
        rd_op(8'hD8);
        check("t6_alm_kept", 32'(io_rdata), 32'h5A);

        // Randomised traffic against the model.
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            int k;
            rin = ($urandom_range(0, 499) == 0);
            if (restim) restim = ($urandom_range(0, 7) != 0);
            else        restim = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 49) == 0) gie = ~gie;
            io_wr = ($urandom_range(0, 3) == 0);
            io_rd = ($urandom_range(0, 2) == 0);
            k = $urandom_range(0, 12);
            io_addr  = (k == 12) ? 8'($urandom) : addrs[k];
            io_wdata = 8'($urandom);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
